// File: rtl/pong_pkg.sv
// Shared pong types: game-flow state encoding and common field widths.
package pong_pkg;

  localparam int unsigned SCORE_W = 4;
  localparam int unsigned CNT_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

endpackage

// File: rtl/match_ctrl_if.sv
// Game-flow bus: ball/sync/button inputs and score/flag outputs of match_ctrl.
interface match_ctrl_if;
  import pong_pkg::*;

  logic               v_sync;
  logic               lft_collision;
  logic               rgt_collision;
  logic               start;
  logic [SCORE_W-1:0] lft_score;
  logic [SCORE_W-1:0] rgt_score;
  logic               lft_win;
  logic               rgt_win;
  logic               ball_run;
  logic               serve_dir;
  logic               point_pulse;

  modport slave (
    input  v_sync, lft_collision, rgt_collision, start,
    output lft_score, rgt_score, lft_win, rgt_win, ball_run, serve_dir, point_pulse
  );

  modport master (
    output v_sync, lft_collision, rgt_collision, start,
    input  lft_score, rgt_score, lft_win, rgt_win, ball_run, serve_dir, point_pulse
  );
endinterface

// File: rtl/edge_det.sv
// Single-cycle edge strobe from a level; RISING selects rising or falling edge.
module edge_det #(
  parameter bit RISING = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse_c
);

  logic prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= din;
  end

  assign pulse_c = RISING ? (din & ~prev_q) : (~din & prev_q);

endmodule

// File: rtl/match_ctrl.sv
// Pong match sequencer: scores misses, paces serves on frame ticks, flags the winner.
module match_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned WIN_SCORE    = 9,
  parameter int unsigned SERVE_FRAMES = 60
) (
  input  logic        clk_25MHz,
  input  logic        reset,
  match_ctrl_if.slave bus
);

  localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0]   SERVE_CNT = CNT_W'(SERVE_FRAMES);

  logic start_s1_q, start_s2_q;
  logic start_edge_c, lft_edge_c, rgt_edge_c, frame_tick_c;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCORE_W-1:0] lft_score_q, lft_score_d, rgt_score_q, rgt_score_d;
  logic               lft_win_q, lft_win_d, rgt_win_q, rgt_win_d;
  logic               serve_dir_q, serve_dir_d, point_q, point_d, ball_run_q, ball_run_d;

  // Button is asynchronous; collisions come from the same clock domain.
  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      start_s1_q <= 1'b0;
      start_s2_q <= 1'b0;
    end else begin
      start_s1_q <= bus.start;
      start_s2_q <= start_s1_q;
    end
  end

  edge_det #(.RISING(1'b1)) u_start_edge (.clk(clk_25MHz), .rst(reset), .din(start_s2_q),        .pulse_c(start_edge_c));
  edge_det #(.RISING(1'b1)) u_lft_edge   (.clk(clk_25MHz), .rst(reset), .din(bus.lft_collision), .pulse_c(lft_edge_c));
  edge_det #(.RISING(1'b1)) u_rgt_edge   (.clk(clk_25MHz), .rst(reset), .din(bus.rgt_collision), .pulse_c(rgt_edge_c));
  edge_det #(.RISING(1'b0)) u_frame_tick (.clk(clk_25MHz), .rst(reset), .din(bus.v_sync),        .pulse_c(frame_tick_c));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lft_score_d = lft_score_q;
    rgt_score_d = rgt_score_q;
    lft_win_d   = lft_win_q;
    rgt_win_d   = rgt_win_q;
    serve_dir_d = serve_dir_q;
    point_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_edge_c) begin
          state_d     = ST_SERVE;
          lft_score_d = '0;
          rgt_score_d = '0;
          cnt_d       = SERVE_CNT;
        end
      end
      ST_SERVE: begin
        if (frame_tick_c) begin
          if (cnt_q == '0) state_d = ST_PLAY;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      ST_PLAY: begin
        // A left-edge miss takes priority when both edges land together.
        if (lft_edge_c) begin
          rgt_score_d = rgt_score_q + SCORE_W'(1);
          serve_dir_d = 1'b0;
          point_d     = 1'b1;
          if (rgt_score_d == WIN_VAL) begin
            state_d   = ST_OVER;
            rgt_win_d = 1'b1;
          end else begin
            state_d = ST_SERVE;
            cnt_d   = SERVE_CNT;
          end
        end else if (rgt_edge_c) begin
          lft_score_d = lft_score_q + SCORE_W'(1);
          serve_dir_d = 1'b1;
          point_d     = 1'b1;
          if (lft_score_d == WIN_VAL) begin
            state_d   = ST_OVER;
            lft_win_d = 1'b1;
          end else begin
            state_d = ST_SERVE;
            cnt_d   = SERVE_CNT;
          end
        end
      end
      ST_OVER: begin
        if (start_edge_c) begin
          state_d     = ST_SERVE;
          lft_score_d = '0;
          rgt_score_d = '0;
          lft_win_d   = 1'b0;
          rgt_win_d   = 1'b0;
          cnt_d       = SERVE_CNT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ball_run_d = (state_d == ST_PLAY);
  end

  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      lft_score_q <= '0;
      rgt_score_q <= '0;
      lft_win_q   <= 1'b0;
      rgt_win_q   <= 1'b0;
      serve_dir_q <= 1'b1;
      point_q     <= 1'b0;
      ball_run_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lft_score_q <= lft_score_d;
      rgt_score_q <= rgt_score_d;
      lft_win_q   <= lft_win_d;
      rgt_win_q   <= rgt_win_d;
      serve_dir_q <= serve_dir_d;
      point_q     <= point_d;
      ball_run_q  <= ball_run_d;
    end
  end

  assign bus.lft_score   = lft_score_q;
  assign bus.rgt_score   = rgt_score_q;
  assign bus.lft_win     = lft_win_q;
  assign bus.rgt_win     = rgt_win_q;
  assign bus.ball_run    = ball_run_q;
  assign bus.serve_dir   = serve_dir_q;
  assign bus.point_pulse = point_q;

endmodule

// File: tb/tb_match_ctrl.sv
// Directed bench for match_ctrl with WIN_SCORE=3, SERVE_FRAMES=2.
module tb_match_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   ncmp = 0;
  int   nerr = 0;

  match_ctrl_if mif ();

  match_ctrl #(.WIN_SCORE(3), .SERVE_FRAMES(2)) dut (
    .clk_25MHz (clk),
    .reset     (reset),
    .bus       (mif)
  );

  always #20 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame_tick();
    mif.v_sync = 1'b0;
    step(3);
    mif.v_sync = 1'b1;
    step(3);
  endtask

  task automatic serve_wait();
    repeat (3) frame_tick();
    ncmp++; if (mif.ball_run !== 1'b1) begin nerr++; $display("FAIL serve_wait_run got %0b want 1", mif.ball_run); end
  endtask

  task automatic test_reset();
    mif.v_sync = 1'b1; mif.lft_collision = 1'b0; mif.rgt_collision = 1'b0; mif.start = 1'b0;
    reset = 1'b1;
    step(2);
    ncmp++; if (mif.lft_score !== 4'd0)   begin nerr++; $display("FAIL rst_lft got %0d want 0", mif.lft_score); end
    ncmp++; if (mif.rgt_score !== 4'd0)   begin nerr++; $display("FAIL rst_rgt got %0d want 0", mif.rgt_score); end
    ncmp++; if ({mif.lft_win, mif.rgt_win} !== 2'b00) begin nerr++; $display("FAIL rst_win got %b want 00", {mif.lft_win, mif.rgt_win}); end
    ncmp++; if (mif.ball_run !== 1'b0)    begin nerr++; $display("FAIL rst_run got %0b want 0", mif.ball_run); end
    ncmp++; if (mif.serve_dir !== 1'b1)   begin nerr++; $display("FAIL rst_dir got %0b want 1", mif.serve_dir); end
    ncmp++; if (mif.point_pulse !== 1'b0) begin nerr++; $display("FAIL rst_pulse got %0b want 0", mif.point_pulse); end
    reset = 1'b0;
    step(2);
    frame_tick();
    ncmp++; if (mif.ball_run !== 1'b0)    begin nerr++; $display("FAIL idle_run got %0b want 0", mif.ball_run); end
  endtask

  task automatic test_serve();
    mif.start = 1'b1;
    step(4);
    mif.start = 1'b0;
    step(2);
    frame_tick();
    frame_tick();
    ncmp++; if (mif.ball_run !== 1'b0) begin nerr++; $display("FAIL serve_early_run got %0b want 0", mif.ball_run); end
    mif.v_sync = 1'b0;
    ncmp++; if (mif.ball_run !== 1'b0) begin nerr++; $display("FAIL serve_tick3_run got %0b want 0", mif.ball_run); end
    step(1);
    ncmp++; if (mif.ball_run !== 1'b1) begin nerr++; $display("FAIL serve_rise_run got %0b want 1", mif.ball_run); end
    step(2);
    mif.v_sync = 1'b1;
    step(2);
    ncmp++; if ({mif.lft_score, mif.rgt_score} !== 8'h00) begin nerr++; $display("FAIL serve_scores got %h want 00", {mif.lft_score, mif.rgt_score}); end
  endtask

  task automatic test_point();
    mif.rgt_collision = 1'b1;
    step(1);
    ncmp++; if (mif.point_pulse !== 1'b1) begin nerr++; $display("FAIL pt_pulse got %0b want 1", mif.point_pulse); end
    ncmp++; if (mif.lft_score !== 4'd1)   begin nerr++; $display("FAIL pt_lft got %0d want 1", mif.lft_score); end
    ncmp++; if (mif.serve_dir !== 1'b1)   begin nerr++; $display("FAIL pt_dir got %0b want 1", mif.serve_dir); end
    ncmp++; if (mif.ball_run !== 1'b0)    begin nerr++; $display("FAIL pt_run got %0b want 0", mif.ball_run); end
    step(1);
    ncmp++; if (mif.point_pulse !== 1'b0) begin nerr++; $display("FAIL pt_pulse_once got %0b want 0", mif.point_pulse); end
    step(3);
    mif.rgt_collision = 1'b0;
    step(1);
    ncmp++; if (mif.lft_score !== 4'd1)   begin nerr++; $display("FAIL pt_held_lft got %0d want 1", mif.lft_score); end
    // Collision during the serve pause must be ignored.
    mif.lft_collision = 1'b1;
    step(1);
    ncmp++; if (mif.point_pulse !== 1'b0) begin nerr++; $display("FAIL serve_coll_pulse got %0b want 0", mif.point_pulse); end
    mif.lft_collision = 1'b0;
    step(1);
    ncmp++; if (mif.rgt_score !== 4'd0)   begin nerr++; $display("FAIL serve_coll_rgt got %0d want 0", mif.rgt_score); end
    serve_wait();
  endtask

  task automatic test_same_cycle();
    mif.lft_collision = 1'b1;
    mif.rgt_collision = 1'b1;
    step(1);
    ncmp++; if (mif.rgt_score !== 4'd1)   begin nerr++; $display("FAIL both_rgt got %0d want 1", mif.rgt_score); end
    ncmp++; if (mif.lft_score !== 4'd1)   begin nerr++; $display("FAIL both_lft got %0d want 1", mif.lft_score); end
    ncmp++; if (mif.serve_dir !== 1'b0)   begin nerr++; $display("FAIL both_dir got %0b want 0", mif.serve_dir); end
    ncmp++; if (mif.point_pulse !== 1'b1) begin nerr++; $display("FAIL both_pulse got %0b want 1", mif.point_pulse); end
    step(1);
    mif.lft_collision = 1'b0;
    mif.rgt_collision = 1'b0;
    step(1);
    serve_wait();
  endtask

  task automatic test_win();
    mif.rgt_collision = 1'b1;
    step(1);
    mif.rgt_collision = 1'b0;
    ncmp++; if (mif.lft_score !== 4'd2) begin nerr++; $display("FAIL win_pt2 got %0d want 2", mif.lft_score); end
    serve_wait();
    mif.rgt_collision = 1'b1;
    step(1);
    mif.rgt_collision = 1'b0;
    ncmp++; if (mif.lft_score !== 4'd3)  begin nerr++; $display("FAIL win_lft got %0d want 3", mif.lft_score); end
    ncmp++; if (mif.lft_win !== 1'b1)    begin nerr++; $display("FAIL win_flag got %0b want 1", mif.lft_win); end
    ncmp++; if (mif.rgt_win !== 1'b0)    begin nerr++; $display("FAIL win_rflag got %0b want 0", mif.rgt_win); end
    repeat (4) frame_tick();
    ncmp++; if (mif.ball_run !== 1'b0)   begin nerr++; $display("FAIL over_run got %0b want 0", mif.ball_run); end
    mif.rgt_collision = 1'b1;
    step(1);
    ncmp++; if (mif.point_pulse !== 1'b0) begin nerr++; $display("FAIL over_pulse got %0b want 0", mif.point_pulse); end
    mif.rgt_collision = 1'b0;
    step(1);
    ncmp++; if (mif.lft_score !== 4'd3)  begin nerr++; $display("FAIL over_lft got %0d want 3", mif.lft_score); end
  endtask

  task automatic test_restart();
    mif.start = 1'b1;
    step(1);
    mif.start = 1'b0;
    step(1);
    ncmp++; if (mif.lft_win !== 1'b1) begin nerr++; $display("FAIL restart_early got %0b want 1", mif.lft_win); end
    step(2);
    ncmp++; if ({mif.lft_score, mif.rgt_score} !== 8'h00) begin nerr++; $display("FAIL restart_scores got %h want 00", {mif.lft_score, mif.rgt_score}); end
    ncmp++; if ({mif.lft_win, mif.rgt_win} !== 2'b00) begin nerr++; $display("FAIL restart_win got %b want 00", {mif.lft_win, mif.rgt_win}); end
    ncmp++; if (mif.ball_run !== 1'b0) begin nerr++; $display("FAIL restart_run got %0b want 0", mif.ball_run); end
    serve_wait();
    mif.start = 1'b1;
    step(2);
    mif.start = 1'b0;
    step(6);
    ncmp++; if (mif.ball_run !== 1'b1) begin nerr++; $display("FAIL play_start_run got %0b want 1", mif.ball_run); end
  endtask

  task automatic test_async_reset();
    mif.rgt_collision = 1'b1;
    step(1);
    mif.rgt_collision = 1'b0;
    serve_wait();
    mif.rgt_collision = 1'b1;
    step(1);
    mif.rgt_collision = 1'b0;
    step(2);
    ncmp++; if (mif.lft_score !== 4'd2) begin nerr++; $display("FAIL ar_pre_lft got %0d want 2", mif.lft_score); end
    #5 reset = 1'b1;
    #1;
    ncmp++; if (mif.lft_score !== 4'd0)   begin nerr++; $display("FAIL ar_lft got %0d want 0", mif.lft_score); end
    ncmp++; if (mif.serve_dir !== 1'b1)   begin nerr++; $display("FAIL ar_dir got %0b want 1", mif.serve_dir); end
    ncmp++; if (mif.ball_run !== 1'b0)    begin nerr++; $display("FAIL ar_run got %0b want 0", mif.ball_run); end
    step(1);
    reset = 1'b0;
    step(2);
    repeat (4) frame_tick();
    ncmp++; if (mif.ball_run !== 1'b0)    begin nerr++; $display("FAIL ar_idle_run got %0b want 0", mif.ball_run); end
  endtask

  initial begin
    test_reset();
    test_serve();
    test_point();
    test_same_cycle();
    test_win();
    test_restart();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
